// File: rtl/mult32x32_fast_fsm.sv
// Control FSM for the 32x32 fast sequential multiplier; sequences byte/word partial products.
// Optional MULT_FSM_DONE_EN adds a one-cycle registered done pulse in the product-valid cycle.
module mult32x32_fast_fsm #(
  parameter bit SKIP_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       a_msb_is_0,
  input  logic       b_msw_is_0,
  output logic       busy,
  output logic [1:0] a_sel,
  output logic       b_sel,
  output logic [2:0] shift_sel,
  output logic       upd_prod,
  output logic       clr_prod
`ifdef MULT_FSM_DONE_EN
  ,
  output logic       done
`endif
);

  typedef enum logic [3:0] {
    IDLE, S00, S10, S20, S30, S01, S11, S21, S31
  } state_t;

  state_t state_reg, state_next;
  logic   skip_a, skip_b;

  assign skip_a = SKIP_EN && a_msb_is_0;
  assign skip_b = SKIP_EN && b_msw_is_0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    upd_prod   = 1'b1;
    clr_prod   = 1'b0;
    a_sel      = 2'd0;
    b_sel      = 1'b0;
    case (state_reg)
      IDLE: begin
        busy     = 1'b0;
        upd_prod = 1'b0;
        // Gated so the clear strobe stays low while reset is held.
        clr_prod = start && !reset;
        if (start) state_next = S00;
      end
      S00: state_next = S10;
      S10: begin
        a_sel      = 2'd1;
        state_next = S20;
      end
      S20: begin
        a_sel = 2'd2;
        if (!skip_a)     state_next = S30;
        else if (skip_b) state_next = IDLE;
        else             state_next = S01;
      end
      S30: begin
        a_sel      = 2'd3;
        state_next = skip_b ? IDLE : S01;
      end
      S01: begin
        b_sel      = 1'b1;
        state_next = S11;
      end
      S11: begin
        a_sel      = 2'd1;
        b_sel      = 1'b1;
        state_next = S21;
      end
      S21: begin
        a_sel      = 2'd2;
        b_sel      = 1'b1;
        state_next = skip_a ? IDLE : S31;
      end
      S31: begin
        a_sel      = 2'd3;
        b_sel      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        upd_prod   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Partial product (byte i, word j) lands at bit 8*i + 16*j.
  assign shift_sel = {1'b0, a_sel} + {1'b0, b_sel, 1'b0};

`ifdef MULT_FSM_DONE_EN
  logic done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_reg <= 1'b0;
    else       done_reg <= (state_reg != IDLE) && (state_next == IDLE);
  end

  assign done = done_reg;
`endif

endmodule

// File: tb/tb_mult32x32_fast_fsm.sv
// Bench for mult32x32_fast_fsm: skip and no-skip instances driving a behavioural datapath model.
// Checks step sequence, product, back-to-back start, async reset abort and (MULT_FSM_DONE_EN) done.
module tb_mult32x32_fast_fsm;

  logic        clk, reset, start;
  logic [31:0] a_op, b_op;
  logic        a_msb_is_0, b_msw_is_0;
  logic [1:0]  busy_w, b_sel_w, upd_w, clr_w;
  logic [1:0]  a_sel_w [2];
  logic [2:0]  shift_w [2];
`ifdef MULT_FSM_DONE_EN
  logic [1:0]  done_w;
`endif

  int errors = 0;
  int checks = 0;

  assign a_msb_is_0 = (a_op[31:24] == 8'h00);
  assign b_msw_is_0 = (b_op[31:16] == 16'h0000);

  mult32x32_fast_fsm #(.SKIP_EN(1'b1)) dut_skip (
    .clk(clk), .reset(reset), .start(start),
    .a_msb_is_0(a_msb_is_0), .b_msw_is_0(b_msw_is_0),
    .busy(busy_w[0]), .a_sel(a_sel_w[0]), .b_sel(b_sel_w[0]),
    .shift_sel(shift_w[0]), .upd_prod(upd_w[0]),
`ifdef MULT_FSM_DONE_EN
    .done(done_w[0]),
`endif
    .clr_prod(clr_w[0])
  );

  mult32x32_fast_fsm #(.SKIP_EN(1'b0)) dut_full (
    .clk(clk), .reset(reset), .start(start),
    .a_msb_is_0(a_msb_is_0), .b_msw_is_0(b_msw_is_0),
    .busy(busy_w[1]), .a_sel(a_sel_w[1]), .b_sel(b_sel_w[1]),
    .shift_sel(shift_w[1]), .upd_prod(upd_w[1]),
`ifdef MULT_FSM_DONE_EN
    .done(done_w[1]),
`endif
    .clr_prod(clr_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: one accumulating product register per FSM instance.
  logic [63:0] prod_m [2];

  function automatic logic [63:0] pp(input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] as, input logic bs, input logic [2:0] sh);
    logic [7:0]  ab;
    logic [15:0] bw;
    ab = a[8*as +: 8];
    bw = b[16*bs +: 16];
    return (64'(ab) * 64'(bw)) << (8 * sh);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr_w[k])      prod_m[k] <= 64'd0;
      else if (upd_w[k]) prod_m[k] <= prod_m[k] + pp(a_op, b_op, a_sel_w[k], b_sel_w[k], shift_w[k]);
    end
  end

  // Reference step list: column-major walk of (byte i, word j), dropping known-zero partials when skipping.
  int exp_a [2][8];
  int exp_b [2][8];
  int exp_n [2];

  task automatic build_ref(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 2; k++) begin
      exp_n[k] = 0;
      for (int j = 0; j < 2; j++)
        for (int i = 0; i < 4; i++) begin
          if (k == 1 || !((i == 3 && a[31:24] == 0) || (j == 1 && b[31:16] == 0))) begin
            exp_a[k][exp_n[k]] = i;
            exp_b[k][exp_n[k]] = j;
            exp_n[k]++;
          end
        end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_done(input int k, input int c, input logic exp);
`ifdef MULT_FSM_DONE_EN
    chk($sformatf("dut%0d c%0d done", k, c), 64'(done_w[k]), 64'(exp));
`endif
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp_prod);
    int cnt [2];
    build_ref(a, b);
    @(negedge clk);
    a_op = a; b_op = b; start = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d start clr", k), 64'(clr_w[k]), 64'd1);
      chk($sformatf("dut%0d start busy", k), 64'(busy_w[k]), 64'd0);
      cnt[k] = 0;
    end
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
        if (busy_w[k]) cnt[k]++;
        if (c <= exp_n[k]) begin
          chk($sformatf("dut%0d c%0d busy", k, c), 64'(busy_w[k]), 64'd1);
          chk($sformatf("dut%0d c%0d upd", k, c), 64'(upd_w[k]), 64'd1);
          chk($sformatf("dut%0d c%0d clr", k, c), 64'(clr_w[k]), 64'd0);
          chk($sformatf("dut%0d c%0d a_sel", k, c), 64'(a_sel_w[k]), 64'(exp_a[k][c-1]));
          chk($sformatf("dut%0d c%0d b_sel", k, c), 64'(b_sel_w[k]), 64'(exp_b[k][c-1]));
          chk($sformatf("dut%0d c%0d shift", k, c), 64'(shift_w[k]),
              64'(exp_a[k][c-1] + 2 * exp_b[k][c-1]));
          chk_done(k, c, 1'b0);
        end else if (c == exp_n[k] + 1) begin
          chk($sformatf("dut%0d c%0d busy", k, c), 64'(busy_w[k]), 64'd0);
          chk($sformatf("dut%0d product", k), prod_m[k], exp_prod);
          chk_done(k, c, 1'b1);
        end else begin
          chk($sformatf("dut%0d c%0d busy", k, c), 64'(busy_w[k]), 64'd0);
          chk_done(k, c, 1'b0);
        end
      end
    end
    for (int k = 0; k < 2; k++)
      chk($sformatf("dut%0d step count", k), 64'(cnt[k]), 64'(exp_n[k]));
    $display("op a=%08h b=%08h steps=%0d/%0d prod=%016h/%016h", a, b, cnt[0], cnt[1], prod_m[0], prod_m[1]);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] ra, rb;
    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[1] = '{32'h000000FF, 32'h0000FFFF, 64'h0000000000FEFF01};
    vecs[2] = '{32'h00FFFFFF, 32'h12340000, 64'h001233FFEDCC0000};
    vecs[3] = '{32'h80000000, 32'h00000002, 64'h0000000100000000};
    vecs[4] = '{32'h00000000, 32'h00000000, 64'h0000000000000000};
    vecs[5] = '{32'h01000000, 32'h00010000, 64'h0000010000000000};

    reset = 1'b1; start = 1'b0; a_op = 32'd0; b_op = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d reset busy", k), 64'(busy_w[k]), 64'd0);
      chk($sformatf("dut%0d reset upd", k), 64'(upd_w[k]), 64'd0);
      chk($sformatf("dut%0d reset clr", k), 64'(clr_w[k]), 64'd0);
      chk($sformatf("dut%0d reset shift", k), 64'(shift_w[k]), 64'd0);
      chk_done(k, 0, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) run_op(vecs[v].a, vecs[v].b, vecs[v].prod);

    // Reset asserted mid-operation while both instances sit in S11.
    build_ref(32'h01000000, 32'h00010000);
    @(negedge clk);
    a_op = 32'h01000000; b_op = 32'h00010000; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("dut%0d pre-abort shift", k), 64'(shift_w[k]), 64'd3);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d abort busy", k), 64'(busy_w[k]), 64'd0);
      chk($sformatf("dut%0d abort upd", k), 64'(upd_w[k]), 64'd0);
      chk($sformatf("dut%0d abort a_sel", k), 64'(a_sel_w[k]), 64'd0);
      chk($sformatf("dut%0d abort b_sel", k), 64'(b_sel_w[k]), 64'd0);
      chk($sformatf("dut%0d abort shift", k), 64'(shift_w[k]), 64'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d post-abort busy", k), 64'(busy_w[k]), 64'd0);
        chk_done(k, c, 1'b0);
      end
    end
    $display("op reset abort in S11 checked");
    run_op(32'h01000000, 32'h00010000, 64'h0000010000000000);

    // Start held high: two back-to-back 3-step runs on the skipping instance.
    @(negedge clk);
    a_op = 32'h000000FF; b_op = 32'h0000FFFF; start = 1'b1;
    #1;
    chk("hold start clr", 64'(clr_w[0]), 64'd1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      if (c % 4 == 0) begin
        chk($sformatf("hold c%0d busy", c), 64'(busy_w[0]), 64'd0);
        chk($sformatf("hold c%0d clr", c), 64'(clr_w[0]), 64'd1);
        chk($sformatf("hold c%0d product", c), prod_m[0], 64'h0000000000FEFF01);
        chk_done(0, c, 1'b1);
      end else begin
        chk($sformatf("hold c%0d busy", c), 64'(busy_w[0]), 64'd1);
        chk($sformatf("hold c%0d clr", c), 64'(clr_w[0]), 64'd0);
        chk($sformatf("hold c%0d shift", c), 64'(shift_w[0]), 64'(c % 4 - 1));
        chk_done(0, c, 1'b0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("dut%0d settle busy", k), 64'(busy_w[k]), 64'd0);
    $display("op hold-start back-to-back a=000000ff b=0000ffff checked");

    for (int r = 0; r < 16; r++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) ra[31:24] = 8'h00;
      if ($urandom_range(0, 1) == 1) rb[31:16] = 16'h0000;
      run_op(ra, rb, 64'(ra) * 64'(rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult32x32_fast_fsm.md
Name: mult32x32_fast_fsm

Overview:
Control FSM for the 32x32 fast sequential multiplier. It drives the select and product-register strobes of the multiplier arithmetic datapath. That datapath contains an 8-bit A-byte mux, a 16-bit B-word mux, a 16x8 multiplier, a shifter and a 64-bit accumulating product register. The FSM reads the datapath's a_msb_is_0 and b_msw_is_0 flags to skip partial products that are known to be zero. Top level = this FSM plus the arithmetic unit, with matching port names wired point-to-point.

Parameters:
- SKIP_EN, 1, 1 = use the zero flags to skip steps; 0 = always run all 8 steps (slow-mode reference behaviour).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high; clock clk
- start  input  1  begin a multiplication; sampled only in IDLE
- a_msb_is_0  input  1  from datapath: a[31:24]==0
- b_msw_is_0  input  1  from datapath: b[31:16]==0
- busy  output  1  high while a multiplication is in progress
- a_sel  output  2  A byte select to datapath
- b_sel  output  1  B word select to datapath
- shift_sel  output  3  shift select to datapath; partial product shifted by 8*shift_sel
- upd_prod  output  1  accumulate the partial product into the product register
- clr_prod  output  1  clear the product register

Behaviour:
- States: IDLE, then eight step states S(i,j) with i = A byte 0..3 and j = B word 0..1. State is registered; outputs are a combinational decode of state (plus start in IDLE).
- Reset (async, any time, including mid-operation): state=IDLE. busy=0, a_sel=0, b_sel=0, shift_sel=0, upd_prod=0, clr_prod=0.
- IDLE:
  - busy=0, upd_prod=0, selects=0.
  - clr_prod = start (combinational).
  - On start=1, go to S(0,0) at the next edge.
- S(i,j) outputs: busy=1, upd_prod=1, clr_prod=0, a_sel=i, b_sel=j, shift_sel=i+2*j (range 0..5; values 6 and 7 are never driven).
- Step order: S00, S10, S20, S30, S01, S11, S21, S31, then IDLE.
- Skip rules (SKIP_EN=1). Flags are sampled in the state that makes the decision.
  - S20: if a_msb_is_0, skip S30 and go to S01. If b_msw_is_0 as well, go to IDLE.
  - S30: if b_msw_is_0, go to IDLE; else go to S01.
  - S21: if a_msb_is_0, go to IDLE; else go to S31.
  - S31: go to IDLE.
- With SKIP_EN=0 the flags are ignored.
- Step counts:
  - full: 8
  - a_msb_is_0 only: 6
  - b_msw_is_0 only: 4
  - both: 3
- Latency: start cycle plus N step cycles. The product is final at the edge leaving the last step, so it is valid in the first IDLE cycle, when busy has fallen.
- start while busy is ignored. start held high continuously launches back-to-back operations: one IDLE cycle (with clr_prod) between them.
- The caller keeps a and b stable from the start cycle until busy falls. The flags are assumed constant over the operation.

Optional Feature:
- Macro MULT_FSM_DONE_EN.
- Defined: adds output port done (1 bit). done is a registered pulse, high for exactly one cycle in the first IDLE cycle after the final step, i.e. the product-valid cycle. done resets to 0 and is never asserted after a reset-aborted operation.
- Undefined: the done port and its register do not exist, and busy falling is the only completion indication.

Test Plan:
- a=0xFFFFFFFF, b=0xFFFFFFFF, start 1 cycle -> clr_prod=1 in the start cycle. 8 busy cycles with shift_sel 0,1,2,3,2,3,4,5. product=0xFFFFFFFE00000001 when busy falls.
- a=0x000000FF, b=0x0000FFFF -> 3 busy cycles (S00,S10,S20) with shift_sel 0,1,2. product=0x0000000000FEFF01.
- a=0x00FFFFFF, b=0x12340000 -> 6 steps with shift_sel 0,1,2,2,3,4; S30 and S31 are never entered. product equals a*b. Same operands with SKIP_EN=0 -> 8 steps, identical product.
- a=0x01000000, b=0x00010000, then reset asserted during S11 -> outputs go to reset values immediately and state=IDLE. A new start then gives 8 steps and product=0x0000010000000000.
- start held high across two operations (a=0xFF, b=0xFFFF) -> start pulses during busy are ignored. One IDLE cycle with clr_prod=1 between the runs, and each run's product=0xFEFF01. With MULT_FSM_DONE_EN, done pulses once per run, in the IDLE cycle.
